// File: rtl/regfile_2r1w_clr.sv
// Two-read/one-write register bank with forwarding, range checks and
// a sequential clear engine. Optional macro: REGFILE_ZERO_REG_EN.
module regfile_2r1w_clr #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int REG_COUNT  = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_err,
    input  logic                  rd_en_a,
    input  logic [ADDR_WIDTH-1:0] rd_addr_a,
    output logic [DATA_WIDTH-1:0] rd_data_a,
    output logic                  rd_valid_a,
    input  logic                  rd_en_b,
    input  logic [ADDR_WIDTH-1:0] rd_addr_b,
    output logic [DATA_WIDTH-1:0] rd_data_b,
    output logic                  rd_valid_b,
    input  logic                  clear_req,
    output logic                  busy
);

    localparam int CW = ADDR_WIDTH + 1;
    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_CLEAR = 1'b1;
    localparam logic [CW-1:0] LAST = CW'(REG_COUNT - 1);
    localparam logic [CW-1:0] NREG = CW'(REG_COUNT);

    typedef logic [DATA_WIDTH-1:0] word_t;

    logic [0:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    word_t         regs_q [REG_COUNT];
    word_t         regs_d [REG_COUNT];
    word_t         rd_data_a_q, rd_data_a_d;
    word_t         rd_data_b_q, rd_data_b_d;
    logic          rd_valid_a_q, rd_valid_a_d;
    logic          rd_valid_b_q, rd_valid_b_d;
    logic          wr_err_q, wr_err_d;

    logic idle_open;
    logic wr_in_range;
    logic wr_zero;
    logic wr_ok;

    // Returns register contents, or zero for an unimplemented address.
    function automatic word_t pick(
        input word_t                 r [REG_COUNT],
        input logic [ADDR_WIDTH-1:0] a
    );
        word_t v;
        v = '0;
        for (int i = 0; i < REG_COUNT; i++) begin
            if ({1'b0, a} == CW'(i)) v = r[i];
        end
        return v;
    endfunction

    // Read value seen by a port, with same-cycle write forwarding.
    function automatic word_t rd_val(input logic [ADDR_WIDTH-1:0] a);
        word_t v;
        if (wr_ok && (wr_addr == a)) v = wr_data;
        else v = pick(regs_q, a);
        return v;
    endfunction

    // Write acceptance: idle, no clear starting, address implemented.
    always_comb begin
        idle_open   = (state_q == S_IDLE) && !clear_req;
        wr_in_range = ({1'b0, wr_addr} < NREG);
`ifdef REGFILE_ZERO_REG_EN
        wr_zero     = idle_open && (wr_addr == '0);
`else
        wr_zero     = 1'b0;
`endif
        wr_ok       = wr_en && idle_open && wr_in_range && !wr_zero;
        wr_err_d    = wr_en && !wr_ok && !wr_zero;
    end

    // Clear engine: walks the counter over every implemented register.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (clear_req) state_d = S_CLEAR;
            end
            S_CLEAR: begin
                if (cnt_q == LAST) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Register array next state: accepted write or one clear step.
    always_comb begin
        regs_d = regs_q;
        for (int i = 0; i < REG_COUNT; i++) begin
            if (wr_ok && ({1'b0, wr_addr} == CW'(i))) regs_d[i] = wr_data;
            if ((state_q == S_CLEAR) && (cnt_q == CW'(i))) regs_d[i] = '0;
        end
`ifdef REGFILE_ZERO_REG_EN
        regs_d[0] = '0;
`endif
    end

    // Read ports: serviced only in IDLE, data held otherwise.
    always_comb begin
        rd_data_a_d  = rd_data_a_q;
        rd_data_b_d  = rd_data_b_q;
        rd_valid_a_d = 1'b0;
        rd_valid_b_d = 1'b0;
        if (state_q == S_IDLE) begin
            if (rd_en_a) begin
                rd_data_a_d  = rd_val(rd_addr_a);
                rd_valid_a_d = 1'b1;
            end
            if (rd_en_b) begin
                rd_data_b_d  = rd_val(rd_addr_b);
                rd_valid_b_d = 1'b1;
            end
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            rd_data_a_q  <= '0;
            rd_data_b_q  <= '0;
            rd_valid_a_q <= 1'b0;
            rd_valid_b_q <= 1'b0;
            wr_err_q     <= 1'b0;
            for (int i = 0; i < REG_COUNT; i++) regs_q[i] <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            rd_data_a_q  <= rd_data_a_d;
            rd_data_b_q  <= rd_data_b_d;
            rd_valid_a_q <= rd_valid_a_d;
            rd_valid_b_q <= rd_valid_b_d;
            wr_err_q     <= wr_err_d;
            regs_q       <= regs_d;
        end
    end

    assign rd_data_a  = rd_data_a_q;
    assign rd_data_b  = rd_data_b_q;
    assign rd_valid_a = rd_valid_a_q;
    assign rd_valid_b = rd_valid_b_q;
    assign wr_err     = wr_err_q;
    assign busy       = (state_q == S_CLEAR);

endmodule

// File: tb/tb_regfile_2r1w_clr.sv
// Scoreboard bench for regfile_2r1w_clr (ADDR_WIDTH=5, REG_COUNT=16).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_regfile_2r1w_clr;

    logic       clock;
    logic       reset;
    logic       wr_en;
    logic [4:0] wr_addr;
    logic [7:0] wr_data;
    logic       wr_err;
    logic       rd_en_a;
    logic [4:0] rd_addr_a;
    logic [7:0] rd_data_a;
    logic       rd_valid_a;
    logic       rd_en_b;
    logic [4:0] rd_addr_b;
    logic [7:0] rd_data_b;
    logic       rd_valid_b;
    logic       clear_req;
    logic       busy;

    int total = 0;
    int bad   = 0;
    logic [7:0] qa[$];
    logic [7:0] qb[$];
    int bcnt;

    regfile_2r1w_clr #(
        .DATA_WIDTH(8),
        .ADDR_WIDTH(5),
        .REG_COUNT (16)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_err    (wr_err),
        .rd_en_a   (rd_en_a),
        .rd_addr_a (rd_addr_a),
        .rd_data_a (rd_data_a),
        .rd_valid_a(rd_valid_a),
        .rd_en_b   (rd_en_b),
        .rd_addr_b (rd_addr_b),
        .rd_data_b (rd_data_b),
        .rd_valid_b(rd_valid_b),
        .clear_req (clear_req),
        .busy      (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clock);
    endtask

    task automatic idle();
        wr_en     = 1'b0;
        rd_en_a   = 1'b0;
        rd_en_b   = 1'b0;
        clear_req = 1'b0;
    endtask

    task automatic wr(input logic [4:0] a, input logic [7:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
    endtask

    task automatic rda(input logic [4:0] a, input logic [7:0] e);
        rd_en_a   = 1'b1;
        rd_addr_a = a;
        qa.push_back(e);
    endtask

    task automatic rdb(input logic [4:0] a, input logic [7:0] e);
        rd_en_b   = 1'b1;
        rd_addr_b = a;
        qb.push_back(e);
    endtask

    // Monitor: every valid strobe must match the oldest queued value.
    always @(negedge clock) begin
        if (reset) begin
            if (rd_valid_a) begin
                if (qa.size() == 0) chk("unexpected_valid_a", 1, 0);
                else chk("rd_data_a", {24'h0, rd_data_a}, {24'h0, qa.pop_front()});
            end
            if (rd_valid_b) begin
                if (qb.size() == 0) chk("unexpected_valid_b", 1, 0);
                else chk("rd_data_b", {24'h0, rd_data_b}, {24'h0, qb.pop_front()});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        rd_addr_a = '0;
        rd_addr_b = '0;
        idle();
        step();
        step();
        chk("rst_rd_data_a", rd_data_a, 0);
        chk("rst_rd_data_b", rd_data_b, 0);
        chk("rst_valid", {rd_valid_a, rd_valid_b}, 0);
        chk("rst_wr_err", wr_err, 0);
        chk("rst_busy", busy, 0);
        reset = 1'b1;
        step();

        // write r3, read two cycles later
        wr(3, 8'hA5);
        step();
        idle();
        step();
        rda(3, 8'hA5);
        step();
        idle();
        step();
        chk("valid_a_one_cycle", rd_valid_a, 0);
        chk("rd_data_b_untouched", rd_data_b, 0);

        // forwarding to both ports
        wr(7, 8'h11);
        step();
        wr(7, 8'h3C);
        rda(7, 8'h3C);
        rdb(7, 8'h3C);
        step();
        idle();
        rda(7, 8'h3C);
        step();
        idle();

        // load all, then clear
        for (int i = 0; i < 16; i++) begin
            wr(5'(i), 8'(8'h10 + i));
            step();
        end
        idle();
        rda(5, 8'h15);
        rdb(15, 8'h1F);
        step();
        idle();
        clear_req = 1'b1;
        wr(1, 8'hEE);
        rda(5, 8'h15);
        step();
        idle();
        chk("wr_err_clear_wins", wr_err, 1);
        bcnt = 0;
        for (int k = 0; k < 40; k++) begin
            if (!busy) break;
            bcnt++;
            if (k == 3) begin
                chk("wr_err_mid_clear", wr_err, 1);
                idle();
            end
            if (k == 2) begin
                wr(2, 8'h55);
                rd_en_b   = 1'b1;
                rd_addr_b = 5'd3;
                clear_req = 1'b1;
            end
            step();
        end
        idle();
        chk("busy_cycles", bcnt, 16);
        for (int i = 0; i < 16; i++) begin
            rda(5'(i), 8'h00);
            rdb(5'(15 - i), 8'h00);
            step();
        end
        idle();
        step();

        // out-of-range address
        wr(4, 8'h44);
        step();
        idle();
        chk("wr_err_in_range", wr_err, 0);
        wr(20, 8'h5A);
        step();
        idle();
        chk("wr_err_out_of_range", wr_err, 1);
        rda(20, 8'h00);
        rdb(4, 8'h44);
        step();
        idle();
        step();
        chk("wr_err_clears", wr_err, 0);

        // async reset mid-clear
        wr(12, 8'hC3);
        step();
        wr(9, 8'h99);
        step();
        idle();
        rda(9, 8'h99);
        rdb(12, 8'hC3);
        step();
        idle();
        clear_req = 1'b1;
        step();
        idle();
        for (int k = 0; k < 5; k++) step();
        chk("busy_before_reset", busy, 1);
        #2;
        reset = 1'b0;
        #1;
        chk("async_busy", busy, 0);
        chk("async_rd_data_a", rd_data_a, 0);
        chk("async_rd_data_b", rd_data_b, 0);
        chk("async_valid_err", {rd_valid_a, rd_valid_b, wr_err}, 0);
        step();
        reset = 1'b1;
        wr(9, 8'h77);
        step();
        idle();
        chk("busy_after_reset", busy, 0);
        rda(9, 8'h77);
        rdb(12, 8'h00);
        step();
        idle();

        // register 0 behaviour
        wr(0, 8'hFF);
        step();
        idle();
        chk("wr_err_r0", wr_err, 0);
`ifdef REGFILE_ZERO_REG_EN
        rda(0, 8'h00);
`else
        rda(0, 8'hFF);
`endif
        step();
        idle();
        step();
        step();

        chk("queue_a_drained", qa.size(), 0);
        chk("queue_b_drained", qb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
